// File: rtl/morse_pkg.sv
// Shared Morse symbol codes and key-timer FSM state encodings.
package morse_pkg;

  localparam int unsigned SYM_W   = 2;
  localparam int unsigned STATE_W = 2;

  localparam logic [SYM_W-1:0] MORSE_NONE = 2'b00;
  localparam logic [SYM_W-1:0] MORSE_DOT  = 2'b01;
  localparam logic [SYM_W-1:0] MORSE_DASH = 2'b10;
  localparam logic [SYM_W-1:0] MORSE_GAP  = 2'b11;

  localparam logic [STATE_W-1:0] ST_IDLE  = 2'd0;
  localparam logic [STATE_W-1:0] ST_MARK  = 2'd1;
  localparam logic [STATE_W-1:0] ST_SPACE = 2'd2;

endpackage

// File: rtl/morse_debounce.sv
// Two-flop synchroniser followed by a stable-count filter on the raw key.
// Latency from a key edge to the level change is 2+DEBOUNCE_CYC cycles for
// both polarities, so mark/space durations survive the filter unchanged.
module morse_debounce #(
  parameter int unsigned DEBOUNCE_CYC = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic key_in,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int unsigned DB_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYC - 1);

  logic            sync1;
  logic            sync2;
  logic [DB_W-1:0] cnt;

  // Synchronise, then accept a new level after DEBOUNCE_CYC differing samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt   <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      sync1 <= key_in;
      sync2 <= sync1;
      rise  <= 1'b0;
      fall  <= 1'b0;
      if (sync2 != level) begin
        if (cnt == DB_LAST) begin
          level <= sync2;
          cnt   <= '0;
          rise  <= sync2;
          fall  <= ~sync2;
        end else begin
          cnt <= cnt + DB_W'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/morse_key_timer.sv
// Times debounced marks and spaces in dot units and emits one-cycle symbol
// codes (dot, dash, letter gap) plus a word-gap pulse for the decoder.
module morse_key_timer
  import morse_pkg::*;
#(
  parameter int unsigned TICK_DIV     = 1000,
  parameter int unsigned DEBOUNCE_CYC = 16,
  parameter int unsigned DASH_UNITS   = 2,
  parameter int unsigned LETTER_UNITS = 3,
  parameter int unsigned WORD_UNITS   = 7,
  parameter int unsigned CNT_W        = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_in,
  output logic [1:0] morse_signal,
  output logic       word_gap,
  output logic       key_level,
  output logic       busy
);

  localparam int unsigned PRE_W = $clog2(TICK_DIV);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] UNIT_MAX = '1;
  localparam logic [CNT_W-1:0] DASH_U   = CNT_W'(DASH_UNITS);
  localparam logic [CNT_W-1:0] LETTER_U = CNT_W'(LETTER_UNITS);
  localparam logic [CNT_W-1:0] WORD_U   = CNT_W'(WORD_UNITS);

  logic               key_rise;
  logic               key_fall;
  logic [STATE_W-1:0] state;
  logic [STATE_W-1:0] state_next;
  logic [PRE_W-1:0]   presc;
  logic [CNT_W-1:0]   units;
  logic               gap_done;
  logic               gap_done_next;
  logic [SYM_W-1:0]   sig_next;
  logic               word_next;

  morse_debounce #(
    .DEBOUNCE_CYC(DEBOUNCE_CYC)
  ) u_debounce (
    .clk   (clk),
    .rst   (rst),
    .key_in(key_in),
    .level (key_level),
    .rise  (key_rise),
    .fall  (key_fall)
  );

  // State, unit timing and registered outputs; timers restart on every state entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      presc        <= '0;
      units        <= '0;
      gap_done     <= 1'b0;
      morse_signal <= MORSE_NONE;
      word_gap     <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state        <= state_next;
      morse_signal <= sig_next;
      word_gap     <= word_next;
      busy         <= (state_next != ST_IDLE);
      if (state_next != state) begin
        presc    <= '0;
        units    <= '0;
        gap_done <= 1'b0;
      end else begin
        gap_done <= gap_done_next;
        if (presc == PRE_LAST) begin
          presc <= '0;
          if (units != UNIT_MAX) begin
            units <= units + CNT_W'(1);
          end
        end else begin
          presc <= presc + PRE_W'(1);
        end
      end
    end
  end

  // Next state and symbol decisions from key strobes and elapsed units.
  always_comb begin
    state_next    = state;
    gap_done_next = gap_done;
    sig_next      = MORSE_NONE;
    word_next     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (key_rise) state_next = ST_MARK;
      end
      ST_MARK: begin
        if (key_fall) begin
          sig_next   = (units < DASH_U) ? MORSE_DOT : MORSE_DASH;
          state_next = ST_SPACE;
        end
      end
      ST_SPACE: begin
        if ((units == LETTER_U) && !gap_done) begin
          sig_next      = MORSE_GAP;
          gap_done_next = 1'b1;
        end
        if (units == WORD_U) begin
          word_next  = 1'b1;
          state_next = ST_IDLE;
        end
        if (key_rise) state_next = ST_MARK;
      end
      default: state_next = ST_IDLE;
    endcase
  end

endmodule
